// File: rtl/shift_ctrl.sv
// Serial-to-parallel framing controller with a valid/ready word handshake and a sticky overflow flag.
// Define SHIFT_CTRL_PARITY_EN to add a trailing even-parity bit per word and the parityErr check.
module shift_ctrl #(
   parameter int unsigned DATA_WIDTH = 4
) (
   input  logic                                 fastClk,
   input  logic                                 resetN,
   input  logic                                 start,
   input  logic                                 bitIn,
   input  logic                                 bitValid,
   input  logic                                 wordReady,
   input  logic                                 clearErr,
   output logic [DATA_WIDTH-1:0]                wordOut,
   output logic                                 wordValid,
   output logic                                 busy,
   output logic [$clog2(DATA_WIDTH+1)-1:0]      bitCount,
   output logic                                 overflow,
   output logic                                 parityErr
);

   localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

`ifdef SHIFT_CTRL_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY, HOLD} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
`endif

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  valid_q, valid_d;
   logic                  busy_q, busy_d;
   logic                  ovf_q, ovf_d;

   always_ff @(posedge fastClk or negedge resetN) begin
      if (!resetN) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (start) state_d = SHIFT;
         SHIFT: if (bitValid && cnt_q == LAST) begin
`ifdef SHIFT_CTRL_PARITY_EN
            state_d = PARITY;
`else
            state_d = HOLD;
`endif
         end
`ifdef SHIFT_CTRL_PARITY_EN
         PARITY: if (bitValid) state_d = HOLD;
`endif
         HOLD:  if (wordReady) state_d = start ? SHIFT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (start) begin
            shift_d = '0;
            cnt_d   = '0;
         end
         SHIFT: if (bitValid) begin
            shift_d = {shift_q[DATA_WIDTH-2:0], bitIn};
            cnt_d   = cnt_q + CW'(1);
         end
         HOLD: if (wordReady && start) begin
            shift_d = '0;
            cnt_d   = '0;
         end
         default: ;
      endcase
      // Set has priority over clear, including on the accepting cycle.
      ovf_d = clearErr ? 1'b0 : ovf_q;
      if (state_q == HOLD && bitValid) ovf_d = 1'b1;
      valid_d = (state_d == HOLD);
`ifdef SHIFT_CTRL_PARITY_EN
      busy_d  = (state_d == SHIFT) || (state_d == PARITY);
`else
      busy_d  = (state_d == SHIFT);
`endif
   end

   always_ff @(posedge fastClk or negedge resetN) begin
      if (!resetN) begin
         shift_q <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef SHIFT_CTRL_PARITY_EN
   logic perr_q, perr_d;

   always_comb begin
      perr_d = perr_q;
      if (state_q == PARITY && bitValid) perr_d = (^shift_q) ^ bitIn;
      else if (state_q == HOLD && wordReady) perr_d = 1'b0;
   end

   always_ff @(posedge fastClk or negedge resetN) begin
      if (!resetN) perr_q <= 1'b0;
      else         perr_q <= perr_d;
   end

   assign parityErr = perr_q;
`else
   assign parityErr = 1'b0;
`endif

   assign wordOut   = shift_q;
   assign wordValid = valid_q;
   assign busy      = busy_q;
   assign bitCount  = cnt_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Randomised scoreboard bench for shift_ctrl: the driver pushes expected words, a negedge monitor checks them.
// Parity behaviour follows SHIFT_CTRL_PARITY_EN when the bench is built with it.
module tb_shift_ctrl;
   localparam int unsigned W  = 4;
   localparam int unsigned CW = $clog2(W + 1);

   logic          fastClk = 1'b0;
   logic          resetN = 1'b1, start = 1'b0, bitIn = 1'b0, bitValid = 1'b0;
   logic          wordReady = 1'b0, clearErr = 1'b0;
   logic [W-1:0]  wordOut;
   logic          wordValid, busy, overflow, parityErr;
   logic [CW-1:0] bitCount;

   typedef struct packed {
      logic [W-1:0] w;
      logic         perr;
   } exp_t;

   exp_t sb[$];
   int   checks = 0, passes = 0, issued = 0, accepted = 0;
   logic ovf_m = 1'b0;

   shift_ctrl #(.DATA_WIDTH(W)) dut (
      .fastClk(fastClk), .resetN(resetN), .start(start), .bitIn(bitIn),
      .bitValid(bitValid), .wordReady(wordReady), .clearErr(clearErr),
      .wordOut(wordOut), .wordValid(wordValid), .busy(busy),
      .bitCount(bitCount), .overflow(overflow), .parityErr(parityErr)
   );

   always #5 fastClk = ~fastClk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick;
      @(posedge fastClk);
      #1;
   endtask

   // Monitor: every held word must match the scoreboard head; it retires on acceptance.
   always @(negedge fastClk) begin
      if (resetN && wordValid) begin
         if (sb.size() == 0) begin
            check("unexpected_word", 32'(wordOut), 32'hFFFF_FFFF);
         end else begin
            check("word_out", 32'(wordOut), 32'(sb[0].w));
            check("parity_err", 32'(parityErr), 32'(sb[0].perr));
            if (wordReady) begin
               void'(sb.pop_front());
               accepted++;
            end
         end
      end
   end

   task automatic start_word;
      start = 1'b1;
      bitValid = 1'($urandom);
      bitIn = 1'($urandom);
      tick;
      start = 1'b0;
      bitValid = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      check("count_after_start", 32'(bitCount), 32'd0);
   endtask

   task automatic shift_bits(input logic [W-1:0] w, input int unsigned gap_max, input logic p);
      exp_t e;
      for (int i = int'(W) - 1; i >= 0; i--) begin
         repeat ($urandom_range(gap_max, 0)) begin
            bitValid = 1'b0;
            bitIn = 1'($urandom);
            tick;
         end
         bitValid = 1'b1;
         bitIn = w[i];
         tick;
      end
`ifdef SHIFT_CTRL_PARITY_EN
      repeat ($urandom_range(gap_max, 0)) begin
         bitValid = 1'b0;
         tick;
      end
      bitValid = 1'b1;
      bitIn = p;
      tick;
      e.perr = (^w) ^ p;
`else
      e.perr = 1'b0;
      if (p === 1'bx) e.perr = 1'b0;
`endif
      e.w = w;
      sb.push_back(e);
      issued++;
      bitValid = 1'b0;
      check("count_full", 32'(bitCount), 32'(W));
      check("valid_in_hold", 32'(wordValid), 32'd1);
      check("busy_in_hold", 32'(busy), 32'd0);
   endtask

   task automatic hold(input int unsigned waits, input bit noisy, input bit b2b);
      logic bv, clr;
      repeat (waits) begin
         bv  = noisy && ($urandom % 3 == 0);
         clr = noisy && ($urandom % 4 == 0);
         bitValid = bv;
         bitIn = 1'($urandom);
         clearErr = clr;
         wordReady = 1'b0;
         tick;
         ovf_m = bv ? 1'b1 : (clr ? 1'b0 : ovf_m);
         check("overflow_hold", 32'(overflow), 32'(ovf_m));
         check("valid_held", 32'(wordValid), 32'd1);
      end
      bv = noisy && ($urandom % 3 == 0);
      bitValid = bv;
      clearErr = 1'b0;
      wordReady = 1'b1;
      start = b2b;
      tick;
      if (bv) ovf_m = 1'b1;
      wordReady = 1'b0;
      start = 1'b0;
      bitValid = 1'b0;
      check("overflow_accept", 32'(overflow), 32'(ovf_m));
      check("valid_drop", 32'(wordValid), 32'd0);
      check("busy_after_accept", 32'(busy), 32'(b2b));
      check("parity_clear", 32'(parityErr), 32'd0);
      if (b2b) check("count_b2b", 32'(bitCount), 32'd0);
   endtask

   initial begin
      logic [W-1:0] w;
      bit           in_shift;

      #3 resetN = 1'b0;
      #2 check("reset_outputs", 32'({wordOut, wordValid, busy, bitCount, overflow, parityErr}), 32'd0);
      repeat (2) @(posedge fastClk);
      @(negedge fastClk) resetN = 1'b1;
      tick;

      // basic framing
      start_word;
      shift_bits(4'b1011, 0, 1'b1);
      hold(0, 1'b0, 1'b0);

      // stalls and backpressure
      start_word;
      shift_bits(4'b0110, 3, 1'b0);
      hold(5, 1'b0, 1'b0);

      // overflow set / set-beats-clear / clear
      start_word;
      shift_bits(4'b1100, 0, 1'b0);
      bitValid = 1'b1;
      tick;
      ovf_m = 1'b1;
      check("ovf_set", 32'(overflow), 32'd1);
      clearErr = 1'b1;
      tick;
      check("ovf_set_wins", 32'(overflow), 32'd1);
      bitValid = 1'b0;
      tick;
      ovf_m = 1'b0;
      clearErr = 1'b0;
      check("ovf_cleared", 32'(overflow), 32'd0);
      hold(0, 1'b0, 1'b0);

      // back-to-back words
      start_word;
      shift_bits(4'b0101, 0, 1'b1);
      hold(0, 1'b0, 1'b1);
      shift_bits(4'hF, 0, 1'b0);
      hold(0, 1'b0, 1'b0);

      // reset mid-word
      start_word;
      bitValid = 1'b1;
      bitIn = 1'b1;
      tick;
      bitIn = 1'b0;
      tick;
      bitValid = 1'b0;
      #2 resetN = 1'b0;
      #1 check("reset_mid_word", 32'({wordOut, wordValid, busy, bitCount, overflow, parityErr}), 32'd0);
      @(negedge fastClk) resetN = 1'b1;
      ovf_m = 1'b0;
      tick;
      start_word;
      shift_bits(4'b0001, 0, 1'b1);
      hold(1, 1'b0, 1'b0);

      // parity good / bad (parityErr expected 0 when compiled out)
      start_word;
      shift_bits(4'b1011, 0, 1'b1);
      hold(1, 1'b0, 1'b0);
      start_word;
      shift_bits(4'b1011, 0, 1'b0);
      hold(1, 1'b0, 1'b0);

      // randomised traffic, idle garbage, overflow noise, chained words
      in_shift = 1'b0;
      repeat (40) begin
         w = W'($urandom);
         if (!in_shift) begin
            repeat ($urandom_range(2, 0)) begin
               bitValid = 1'($urandom);
               bitIn = 1'($urandom);
               tick;
               check("idle_busy", 32'(busy), 32'd0);
               check("idle_ovf", 32'(overflow), 32'(ovf_m));
            end
            bitValid = 1'b0;
            start_word;
         end
         shift_bits(w, 2, 1'($urandom));
         in_shift = ($urandom % 3 == 0);
         hold($urandom_range(4, 0), 1'b1, in_shift);
      end
      if (in_shift) begin
         shift_bits(W'($urandom), 1, 1'($urandom));
         hold(0, 1'b0, 1'b0);
      end

      tick;
      check("all_accepted", 32'(accepted), 32'(issued));
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
